fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: PC_W, default 10, program-counter width; PROG_LEN, default 1024, instruction count (1..2^PC_W); I_W, default 9, instruction width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  one-cycle pulse; begins execution at address 0 from IDLE or DONE.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  PC_W  read address, equal to pc.
REQ-007 imem_ack  input  1  read complete; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  I_W  instruction word.
REQ-009 instr_valid  output  1  instr and opcode hold a fetched instruction.
REQ-010 instr  output  I_W  fetched instruction word.
REQ-011 opcode  output  3  instr[I_W-1:I_W-3]; feeds the control decoder's instr input.
REQ-012 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-013 branch  input  1  decoder Branch signal for the presented instruction.
REQ-014 taken  input  1  branch condition (ALU zero) for the presented instruction.
REQ-015 branch_target  input  PC_W  absolute target address.
REQ-016 retired  output  16  count of accepted instructions, saturating.
REQ-017 done  output  1  program finished; fetch unit idle.

Function
REQ-018 States SHALL be IDLE, FETCH, HOLD, DONE, encoded in a registered state variable.
REQ-019 IDLE: all outputs low; start=1 -> pc=0, retired=0, go FETCH.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_ack=1 at edge -> capture imem_rdata into instr, go HOLD; else stay FETCH with req held high and pc stable.
REQ-021 HOLD: instr_valid=1, imem_req=0; instr, opcode and pc stable until acceptance (instr_valid & instr_ready at edge).
REQ-022 branch, taken and branch_target SHALL be sampled only in the acceptance cycle and ignored otherwise.
REQ-023 On acceptance: next = branch_target if branch & taken, else pc+1, computed PC_W+1 bits wide (no wrap).
REQ-024 On acceptance: next >= PROG_LEN -> go DONE; else pc=next, go FETCH.
REQ-025 Each acceptance SHALL increment retired by 1, holding at 16'hFFFF.
REQ-026 Minimum throughput: one instruction per 2 cycles (ack on first FETCH cycle, ready on first HOLD cycle).
REQ-027 DONE: done=1, instr_valid=0, imem_req=0; retired holds; start=1 -> pc=0, retired=0, done=0, go FETCH.
REQ-028 start SHALL be ignored in FETCH and HOLD.
REQ-029 imem_ack outside FETCH SHALL be ignored.
REQ-030 PROG_LEN=2^PC_W: sequential next from pc=2^PC_W-1 SHALL give DONE, never wrap to 0.

Reset
REQ-031 reset=1 SHALL force, without waiting for clk: state=IDLE, pc=0, instr=0, retired=0, imem_req=0, instr_valid=0, done=0.
REQ-032 reset asserted in FETCH SHALL drop imem_req in the same cycle; an imem_ack that arrives later SHALL be ignored.
REQ-033 After reset deassertion, the block SHALL remain in IDLE until start.

Verification
REQ-034 PROG_LEN=4, ack and ready always high, no branches -> addresses 0,1,2,3 issued every 2 cycles; done=1 after the 4th acceptance; retired=4.
REQ-035 ack delayed 3 cycles at addr 0 -> imem_req and imem_addr=0 held for 4 cycles; instr equals rdata from the ack cycle.
REQ-036 At pc=5, branch=1, taken=1, target=2 on acceptance -> next imem_addr=2; branch=1, taken=0 -> next imem_addr=6.
REQ-037 instr_ready low 5 cycles in HOLD -> instr, opcode and pc stable; no new request; retired unchanged.
REQ-038 reset pulse mid-FETCH with late ack -> outputs zero immediately; IDLE persists; a later start fetches from 0.
REQ-039 PROG_LEN=1024, branch_target=1023, then sequential step -> DONE, no fetch at address 0; start in DONE restarts at 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
//
// Fetches instructions from a ready/ack instruction memory starting at
// address 0, presents each to a downstream decoder with a valid/ready
// handshake, and advances the program counter either sequentially or to an
// absolute branch target. Execution finishes when the next address falls
// outside the program.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 one-cycle pulse, (re)starts execution at address 0
//   imem_req/addr         instruction memory read request and address (= pc)
//   imem_ack/rdata        read completion and instruction word (same cycle)
//   instr_valid/instr     fetched instruction presented downstream
//   opcode                top three bits of instr
//   instr_ready           downstream accepts the presented instruction
//   branch/taken/target   redirect inputs, sampled only in the accept cycle
//   retired               saturating count of accepted instructions
//   done                  program finished, unit idle
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_FETCH | read request outstanding at pc
// S_HOLD  | instruction presented, waiting for instr_ready
// S_DONE  | next address beyond program end, waiting for start

module fetch_unit #(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024,
    parameter int I_W      = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [I_W-1:0]  imem_rdata,
    output logic            instr_valid,
    output logic [I_W-1:0]  instr,
    output logic [2:0]      opcode,
    input  logic            instr_ready,
    input  logic            branch,
    input  logic            taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [15:0]     retired,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One extra bit so PROG_LEN = 2^PC_W is representable and pc+1 never wraps.
    localparam logic [PC_W:0] PROG_LIMIT = (PC_W + 1)'(PROG_LEN);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [I_W-1:0]  instr_q, instr_d;
    logic [15:0]     retired_q, retired_d;
    logic [PC_W:0]   next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        done        = 1'b0;

        if (branch && taken)
            next_pc = {1'b0, branch_target};
        else
            next_pc = {1'b0, pc_q} + (PC_W + 1)'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (retired_q != 16'hFFFF)
                        retired_d = retired_q + 16'd1;
                    if (next_pc >= PROG_LIMIT) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = next_pc[PC_W-1:0];
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[I_W-1 -: 3];
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    // main instance: default parameters
    logic       start = 1'b0;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [8:0] imem_rdata = '0;
    logic       instr_valid;
    logic [8:0] instr;
    logic [2:0] opcode;
    logic       instr_ready = 1'b0;
    logic       branch = 1'b0;
    logic       taken = 1'b0;
    logic [9:0] branch_target = '0;
    logic [15:0] retired;
    logic       done;

    // short-program instance: PROG_LEN = 4, ack and ready always high
    logic       start4 = 1'b0;
    logic       req4;
    logic [9:0] addr4;
    logic       ack4 = 1'b1;
    logic       valid4;
    logic [8:0] instr4;
    logic [2:0] opcode4;
    logic       ready4 = 1'b1;
    logic [15:0] retired4;
    logic       done4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
        .instr_ready(instr_ready), .branch(branch), .taken(taken),
        .branch_target(branch_target), .retired(retired), .done(done)
    );

    fetch_unit #(.PC_W(10), .PROG_LEN(4), .I_W(9)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .imem_req(req4), .imem_addr(addr4),
        .imem_ack(ack4), .imem_rdata(9'h0C0),
        .instr_valid(valid4), .instr(instr4), .opcode(opcode4),
        .instr_ready(ready4), .branch(1'b0), .taken(1'b0),
        .branch_target(10'd0), .retired(retired4), .done(done4)
    );

    typedef struct {
        int         ack_dly;
        int         rdy_dly;
        logic       br;
        logic       tk;
        logic [9:0] tgt;
        logic [8:0] rdata;
        logic [9:0] exp_addr;
        logic       exp_done;
        logic [9:0] exp_next;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        //          ack rdy br  tk  tgt     rdata    addr    done next
        vecs[0] = '{3, 0, 1'b0, 1'b0, 10'd0,    9'h1A5, 10'd0,    1'b0, 10'd1};
        vecs[1] = '{0, 5, 1'b1, 1'b0, 10'd100,  9'h0F3, 10'd1,    1'b0, 10'd2};
        vecs[2] = '{0, 0, 1'b1, 1'b1, 10'd5,    9'h040, 10'd2,    1'b0, 10'd5};
        vecs[3] = '{1, 0, 1'b1, 1'b1, 10'd2,    9'h1FF, 10'd5,    1'b0, 10'd2};
        vecs[4] = '{0, 2, 1'b1, 1'b1, 10'd5,    9'h003, 10'd2,    1'b0, 10'd5};
        vecs[5] = '{0, 0, 1'b1, 1'b0, 10'd300,  9'h0AA, 10'd5,    1'b0, 10'd6};
        vecs[6] = '{2, 1, 1'b1, 1'b1, 10'd1023, 9'h155, 10'd6,    1'b0, 10'd1023};
        vecs[7] = '{0, 0, 1'b0, 1'b0, 10'd0,    9'h123, 10'd1023, 1'b1, 10'd0};

        // reset state
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // short program, back-to-back handshakes: one instruction per 2 cycles
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("p4_req_%0d", k), 32'(req4), 32'((k % 2) == 0));
            chk($sformatf("p4_valid_%0d", k), 32'(valid4), 32'((k % 2) == 1));
            if ((k % 2) == 0)
                chk($sformatf("p4_addr_%0d", k), 32'(addr4), 32'(k / 2));
            step();
        end
        chk("p4_done", 32'(done4), 32'd1);
        chk("p4_req_off", 32'(req4), 32'd0);
        chk("p4_retired", 32'(retired4), 32'd4);
        step();
        chk("p4_done_hold", 32'(done4), 32'd1);
        chk("p4_retired_hold", 32'(retired4), 32'd4);

        // main program from the vector table
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'd1);
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            for (int d = 0; d < vecs[i].ack_dly; d++) begin
                start = 1'b1;
                instr_ready = 1'b1;
                branch = 1'b1; taken = 1'b1; branch_target = 10'd9;
                step();
                chk($sformatf("v%0d_wait%0d_req", i, d), 32'(imem_req), 32'd1);
                chk($sformatf("v%0d_wait%0d_addr", i, d), 32'(imem_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d_wait%0d_valid", i, d), 32'(instr_valid), 32'd0);
            end
            start = 1'b0; instr_ready = 1'b0;
            branch = 1'b0; taken = 1'b0; branch_target = '0;
            imem_ack = 1'b1;
            imem_rdata = vecs[i].rdata;
            step();
            imem_ack = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("v%0d_hold_req", i), 32'(imem_req), 32'd0);
            chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].rdata));
            chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].rdata[8:6]));
            for (int d = 0; d < vecs[i].rdy_dly; d++) begin
                start = 1'b1;
                imem_ack = 1'b1;
                imem_rdata = ~vecs[i].rdata;
                branch = 1'b1; taken = 1'b1; branch_target = 10'd0;
                step();
                chk($sformatf("v%0d_stall%0d_instr", i, d), 32'(instr), 32'(vecs[i].rdata));
                chk($sformatf("v%0d_stall%0d_valid", i, d), 32'(instr_valid), 32'd1);
                chk($sformatf("v%0d_stall%0d_req", i, d), 32'(imem_req), 32'd0);
                chk($sformatf("v%0d_stall%0d_pc", i, d), 32'(imem_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d_stall%0d_ret", i, d), 32'(retired), 32'(i));
            end
            start = 1'b0; imem_ack = 1'b0;
            instr_ready = 1'b1;
            branch = vecs[i].br; taken = vecs[i].tk; branch_target = vecs[i].tgt;
            step();
            instr_ready = 1'b0;
            branch = 1'b0; taken = 1'b0; branch_target = '0;
            chk($sformatf("v%0d_retired", i), 32'(retired), 32'(i + 1));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            if (vecs[i].exp_done) begin
                chk($sformatf("v%0d_done_req", i), 32'(imem_req), 32'd0);
                chk($sformatf("v%0d_done_valid", i), 32'(instr_valid), 32'd0);
            end else begin
                chk($sformatf("v%0d_next_req", i), 32'(imem_req), 32'd1);
                chk($sformatf("v%0d_next_addr", i), 32'(imem_addr), 32'(vecs[i].exp_next));
            end
        end

        // DONE holds and ignores a stray ack; start restarts at 0
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        chk("done_hold", 32'(done), 32'd1);
        chk("done_no_req", 32'(imem_req), 32'd0);
        chk("done_retired", 32'(retired), 32'd8);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", 32'(imem_addr), 32'd0);
        chk("restart_retired", 32'(retired), 32'd0);
        chk("restart_done", 32'(done), 32'd0);

        // advance to pc=1, then reset mid-FETCH
        imem_ack = 1'b1; imem_rdata = 9'h0AB;
        step();
        imem_ack = 1'b0; instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("pre_rst_addr", 32'(imem_addr), 32'd1);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_addr", 32'(imem_addr), 32'd0);
        chk("async_rst_instr", 32'(instr), 32'd0);
        chk("async_rst_retired", 32'(retired), 32'd0);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 9'h1C1;
        for (int d = 0; d < 3; d++) begin
            step();
            chk($sformatf("late_ack%0d_req", d), 32'(imem_req), 32'd0);
            chk($sformatf("late_ack%0d_valid", d), 32'(instr_valid), 32'd0);
            chk($sformatf("late_ack%0d_instr", d), 32'(instr), 32'd0);
        end
        imem_ack = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", 32'(imem_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
